// File: rtl/bfloat_div.sv
`default_nettype none
// ============================================================================
//  Module   : bfloat_div
//  Purpose  : Iterative bfloat16 divider c = a / b. Restoring mantissa
//             division, one quotient bit per cycle, fixed 10-edge latency
//             through start/busy/done. Truncating, denormals flush to zero.
//  Revision : 1.0  initial release
// ============================================================================
module bfloat_div #(
  parameter int          BIAS    = 127,
  parameter logic [15:0] NAN_VAL = 16'h7FC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] c,
  output logic        dz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_PACK = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0]       a_q, a_d, b_q, b_d;
  logic [8:0]        r_q, r_d;
  logic [7:0]        mb_q, mb_d;
  logic signed [9:0] e_q, e_d;
  logic [7:0]        q_q, q_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              spec_q, spec_d;
  logic [15:0]       spec_val_q, spec_val_d;
  logic              spec_dz_q, spec_dz_d;
  logic              busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [15:0]       c_q, c_d;

  // Operand classification and PREP-stage arithmetic on the latched operands
  logic [7:0] ea, eb, ma, mb;
  logic       a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, m_lt;
  logic [9:0] e_prep;

  assign ea     = a_q[14:7];
  assign eb     = b_q[14:7];
  assign ma     = {1'b1, a_q[6:0]};
  assign mb     = {1'b1, b_q[6:0]};
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[6:0] == 7'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[6:0] == 7'd0);
  assign a_nan  = (ea == 8'hFF) && (a_q[6:0] != 7'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[6:0] != 7'd0);
  assign m_lt   = (ma < mb);
  // Pre-normalise: a smaller dividend mantissa costs one exponent step
  assign e_prep = {2'b00, ea} - {2'b00, eb} + BIAS[9:0] - {9'd0, m_lt};

  // One restoring-division step on the current remainder
  logic [8:0] rem;
  logic       qbit;
  always_comb begin
    qbit = 1'b0;
    rem  = r_q;
    if (r_q >= {1'b0, mb_q}) begin
      qbit = 1'b1;
      rem  = r_q - {1'b0, mb_q};
    end
  end

  // Next-state logic for the FSM and the datapath registers
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    mb_d       = mb_q;
    e_d        = e_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    spec_dz_d  = spec_dz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    c_d        = c_q;
    dz_d       = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        sign_d = a_q[15] ^ b_q[15];
        r_d    = m_lt ? {ma, 1'b0} : {1'b0, ma};
        mb_d   = mb;
        e_d    = e_prep;
        q_d    = 8'd0;
        cnt_d  = 3'd7;
        // Special results are resolved here and ride along unchanged
        spec_d     = 1'b1;
        spec_dz_d  = 1'b0;
        spec_val_d = 16'h0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_val_d = NAN_VAL;
        end else if (b_zero) begin
          spec_val_d = {a_q[15] ^ b_q[15], 8'hFF, 7'd0};
          spec_dz_d  = 1'b1;
        end else if (a_inf) begin
          spec_val_d = {a_q[15] ^ b_q[15], 8'hFF, 7'd0};
        end else if (a_zero || b_inf) begin
          spec_val_d = 16'h0000;
        end else begin
          spec_d = 1'b0;
        end
        state_d = S_ITER;
      end
      S_ITER: begin
        q_d   = {q_q[6:0], qbit};
        r_d   = rem << 1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
          state_d = S_PACK;
        end
      end
      S_PACK: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dz_d    = 1'b0;
        state_d = S_IDLE;
        if (spec_q) begin
          c_d  = spec_val_q;
          dz_d = spec_dz_q;
        end else if (e_q >= 10'sd255) begin
          c_d = {sign_q, 8'hFF, 7'd0};
        end else if (e_q <= 10'sd0) begin
          c_d = 16'h0000;
        end else begin
          c_d = {sign_q, e_q[7:0], q_q[6:0]};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register update with synchronous reset taking priority over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      r_q        <= 9'd0;
      mb_q       <= 8'd0;
      e_q        <= 10'sd0;
      q_q        <= 8'd0;
      cnt_q      <= 3'd0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 16'd0;
      spec_dz_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      c_q        <= 16'd0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      mb_q       <= mb_d;
      e_q        <= e_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      spec_dz_q  <= spec_dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      c_q        <= c_d;
      dz_q       <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;
  assign dz   = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_bfloat_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bfloat_div
//  Purpose  : Self-checking bench for bfloat_div: transaction-level reference
//             model, per-cycle output compare, directed and random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bfloat_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        busy, done, dz;
  logic [15:0] c;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  bfloat_div dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .c    (c),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    else n_pass++;
  endtask

  // Reference quotient from the number rules, returns {dz, c}
  function automatic logic [16:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int ea, eb, ma, mb, e, q, sh;
    bit s, az, ai, an, bz, bi, bn;
    logic [7:0] e8;
    logic [7:0] q8;
    ea = int'(x[14:7]); eb = int'(y[14:7]);
    ma = 128 + int'(x[6:0]); mb = 128 + int'(y[6:0]);
    s  = x[15] ^ y[15];
    az = (ea == 0); ai = (ea == 255) && (x[6:0] == 0); an = (ea == 255) && (x[6:0] != 0);
    bz = (eb == 0); bi = (eb == 255) && (y[6:0] == 0); bn = (eb == 255) && (y[6:0] != 0);
    if (an || bn || (az && bz) || (ai && bi)) return {1'b0, 16'h7FC0};
    if (bz) return {1'b1, s, 8'hFF, 7'h0};
    if (ai) return {1'b0, s, 8'hFF, 7'h0};
    if (az || bi) return 17'd0;
    sh = (ma < mb) ? 8 : 7;
    q  = (ma << sh) / mb;
    e  = ea - eb + 127 - ((ma < mb) ? 1 : 0);
    if (e >= 255) return {1'b0, s, 8'hFF, 7'h0};
    if (e <= 0) return 17'd0;
    e8 = e[7:0];
    q8 = q[7:0];
    return {1'b0, s, e8, q8[6:0]};
  endfunction

  // Transaction model: accepted request completes 10 edges later
  int          m_cnt = 0;
  logic        m_done = 1'b0, m_dz = 1'b0;
  logic [15:0] m_c = 16'd0, m_a = 16'd0, m_b = 16'd0;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_done <= 1'b0; m_c <= 16'd0; m_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin m_cnt <= 10; m_a <= a; m_b <= b; end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          {m_dz, m_c} <= ref_div(m_a, m_b);
          m_done <= 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_cnt != 0));
      check("done", 32'(done), 32'(m_done));
      check("c",    32'(c),    32'(m_c));
      check("dz",   32'(dz),   32'(m_dz));
    end
  end

  // Directed operation with literal expectations and latency measurement
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] ec, input logic edz, input string nm);
    int lat;
    check({nm, "_model"}, 32'(ref_div(ta, tb_v)), 32'({edz, ec}));
    @(posedge clk); #1; a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    check({nm, "_lat"}, 32'(lat), 32'd10);
    check({nm, "_c"},   32'(c),   32'(ec));
    check({nm, "_dz"},  32'(dz),  32'(edz));
  endtask

  function automatic logic [15:0] rand_op();
    int sel;
    logic [7:0] e;
    logic [6:0] m;
    sel = $urandom_range(0, 11);
    m = 7'($urandom);
    case (sel)
      0: e = 8'd0;
      1: begin e = 8'hFF; m = 7'd0; end
      2: begin e = 8'hFF; if (m == 7'd0) m = 7'd1; end
      3: e = 8'($urandom_range(1, 254));
      4: e = 8'($urandom_range(240, 254));
      5: e = 8'($urandom_range(1, 12));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  logic [15:0] dir_a [12] = '{16'h3F80, 16'h40C0, 16'hC100, 16'h3F80, 16'h3F80, 16'hBF80,
                              16'h0000, 16'h7FC1, 16'h7F80, 16'h3F80, 16'h7F00, 16'h0080};
  logic [15:0] dir_b [12] = '{16'h3F80, 16'h4000, 16'h3F00, 16'h4040, 16'h0000, 16'h0000,
                              16'h0000, 16'h3F80, 16'h7F80, 16'h7F80, 16'h3E80, 16'h4000};
  logic [15:0] dir_c [12] = '{16'h3F80, 16'h4040, 16'hC180, 16'h3EAA, 16'h7F80, 16'hFF80,
                              16'h7FC0, 16'h7FC0, 16'h7FC0, 16'h0000, 16'h7F80, 16'h0000};
  logic        dir_z [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_c",    32'(c),    32'd0);
    check("rst_dz",   32'(dz),   32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 12; i++) run_op(dir_a[i], dir_b[i], dir_c[i], dir_z[i], $sformatf("dir%0d", i));

    // Starts at T0+3 and T0+9 are ignored; a start in the done cycle is taken
    @(posedge clk); #1; a = 16'h40C0; b = 16'h4000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2 || k == 8) begin start = 1'b1; a = 16'h7FC1; b = 16'h0000; end
      else start = 1'b0;
    end
    check("ign_done", 32'(done), 32'd1);
    check("ign_c",    32'(c),    32'h4040);
    check("ign_dz",   32'(dz),   32'd0);
    a = 16'h3F80; b = 16'h4040; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b2b_lat", 32'(lat), 32'd10);
    check("b2b_c",   32'(c),   32'h3EAA);

    // Reset mid-operation aborts with no done pulse
    @(posedge clk); #1; a = 16'hC100; b = 16'h3F00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_c",    32'(c),    32'd0);
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; check("abort_nodone", 32'(done), 32'd0); end
    run_op(16'h40C0, 16'h4000, 16'h4040, 1'b0, "post_rst");

    // Random traffic, including starts while busy and occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      a = rand_op();
      b = rand_op();
      rst = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1; start = 1'b0; rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
